// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX frame checker.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_ABORT
    } frame_chk_state_e;

    localparam int START_POS = 1;

    localparam int ERR_STRT = 0;
    localparam int ERR_PAR  = 1;
    localparam int ERR_STP  = 2;

    function automatic int stop_pos(input int data_w, input logic par_en);
        return data_w + 2 + int'(par_en);
    endfunction

endpackage

// File: rtl/uart_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module uart_sat_cnt #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_frame_chk.sv
// UART RX frame checker: validates start/parity/stop bits and assembles the data word.
// Optional error/frame counters are enabled with the UART_RX_ERR_CNT_EN macro.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | no frame; waits for chk_en rising
// START    | waiting for the start-bit sample (bit_cnt = 1)
// DATA     | shifting in data bits 2..DATA_W+1
// PAR      | checking the parity bit
// STOP     | checking the stop bit, publishing the frame
// ABORT    | start glitch seen; waits for chk_en low
module uart_rx_frame_chk
    import uart_rx_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int PRESC_W  = 6,
    parameter int BITCNT_W = 4,
    parameter int CNT_W    = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                chk_en,
    input  logic                sampled_bit,
    input  logic [PRESC_W-1:0]  prescale,
    input  logic [PRESC_W-1:0]  edge_cnt,
    input  logic [BITCNT_W-1:0] bit_cnt,
    input  logic                par_en,
    input  logic                par_typ,
    input  logic                err_clr,
    output logic                strt_glitch,
    output logic                par_err,
    output logic                stp_err,
    output logic                frame_vld,
    output logic [DATA_W-1:0]   rx_data,
    output logic [2:0]          err_sticky,
    output logic                chk_busy
`ifdef UART_RX_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]    strt_cnt,
    output logic [CNT_W-1:0]    par_cnt,
    output logic [CNT_W-1:0]    stp_cnt,
    output logic [CNT_W-1:0]    frm_cnt
`endif
);

    localparam logic [BITCNT_W-1:0] START_BIT = BITCNT_W'(START_POS);
    localparam logic [BITCNT_W-1:0] LAST_DATA = BITCNT_W'(DATA_W + 1);

    if (DATA_W < 5 || DATA_W > 9 || (DATA_W + 3 > 2**BITCNT_W - 1) || CNT_W < 1) begin : g_bad_param
        $error("uart_rx_frame_chk: illegal parameter combination");
    end

    frame_chk_state_e    state;
    logic                chk_en_d;
    logic [DATA_W-1:0]   shreg;
    logic                par_run;
    logic                frm_err;
    logic                par_en_q;
    logic                par_typ_q;
    logic [BITCNT_W-1:0] pos;
    logic [BITCNT_W-1:0] stop_bit;
    logic                smp;
    logic [2:0]          err_set;

    // prescale = 0 would wrap prescale-1 to all-ones; it must never strobe
    assign smp      = chk_en && (prescale != '0) && (edge_cnt == prescale - PRESC_W'(1));
    assign stop_bit = BITCNT_W'(stop_pos(DATA_W, par_en_q));
    assign chk_busy = (state != ST_IDLE);

    always_comb begin
        err_set           = '0;
        err_set[ERR_STRT] = strt_glitch;
        err_set[ERR_PAR]  = par_err;
        err_set[ERR_STP]  = stp_err;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= ST_IDLE;
            chk_en_d    <= 1'b0;
            shreg       <= '0;
            par_run     <= 1'b0;
            frm_err     <= 1'b0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            pos         <= '0;
            strt_glitch <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            frame_vld   <= 1'b0;
            rx_data     <= '0;
            err_sticky  <= '0;
        end else begin
            chk_en_d    <= chk_en;
            strt_glitch <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            frame_vld   <= 1'b0;
            // sticky flags follow the registered pulses, so a set always beats err_clr
            err_sticky  <= (err_clr ? 3'b000 : err_sticky) | err_set;

            if (!chk_en) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!chk_en_d) state <= ST_START;
                    end
                    ST_START: begin
                        if (smp && bit_cnt == START_BIT) begin
                            par_en_q  <= par_en;
                            par_typ_q <= par_typ;
                            if (sampled_bit) begin
                                strt_glitch <= 1'b1;
                                state       <= ST_ABORT;
                            end else begin
                                shreg   <= '0;
                                par_run <= 1'b0;
                                frm_err <= 1'b0;
                                pos     <= START_BIT + 1'b1;
                                state   <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (smp && bit_cnt == pos) begin
                            shreg   <= {sampled_bit, shreg[DATA_W-1:1]};
                            par_run <= par_run ^ sampled_bit;
                            pos     <= pos + 1'b1;
                            if (pos == LAST_DATA) state <= par_en_q ? ST_PAR : ST_STOP;
                        end
                    end
                    ST_PAR: begin
                        if (smp && bit_cnt == pos) begin
                            if (sampled_bit != (par_run ^ par_typ_q)) begin
                                par_err <= 1'b1;
                                frm_err <= 1'b1;
                            end
                            state <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (smp && bit_cnt == stop_bit) begin
                            if (!sampled_bit) begin
                                stp_err <= 1'b1;
                            end else if (!frm_err) begin
                                rx_data   <= shreg;
                                frame_vld <= 1'b1;
                            end
                            state <= ST_IDLE;
                        end
                    end
                    ST_ABORT: begin
                        state <= ST_ABORT;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    uart_sat_cnt #(.W(CNT_W)) u_strt_cnt (.CLK(CLK), .RST(RST), .clr(err_clr), .inc(strt_glitch), .cnt(strt_cnt));
    uart_sat_cnt #(.W(CNT_W)) u_par_cnt  (.CLK(CLK), .RST(RST), .clr(err_clr), .inc(par_err),     .cnt(par_cnt));
    uart_sat_cnt #(.W(CNT_W)) u_stp_cnt  (.CLK(CLK), .RST(RST), .clr(err_clr), .inc(stp_err),     .cnt(stp_cnt));
    uart_sat_cnt #(.W(CNT_W)) u_frm_cnt  (.CLK(CLK), .RST(RST), .clr(err_clr), .inc(frame_vld),   .cnt(frm_cnt));
`endif

endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// Self-checking bench for uart_rx_frame_chk against a frame-level reference model.
module tb_uart_rx_frame_chk;

    localparam int DATA_W   = 8;
    localparam int PRESC_W  = 6;
    localparam int BITCNT_W = 4;
    localparam int CNT_W    = 2;
    localparam int CNT_MAX  = 2**CNT_W - 1;

    logic                CLK = 1'b0;
    logic                RST;
    logic                chk_en;
    logic                sampled_bit;
    logic [PRESC_W-1:0]  prescale;
    logic [PRESC_W-1:0]  edge_cnt;
    logic [BITCNT_W-1:0] bit_cnt;
    logic                par_en;
    logic                par_typ;
    logic                err_clr;
    logic                strt_glitch;
    logic                par_err;
    logic                stp_err;
    logic                frame_vld;
    logic [DATA_W-1:0]   rx_data;
    logic [2:0]          err_sticky;
    logic                chk_busy;
`ifdef UART_RX_ERR_CNT_EN
    logic [CNT_W-1:0]    strt_cnt;
    logic [CNT_W-1:0]    par_cnt;
    logic [CNT_W-1:0]    stp_cnt;
    logic [CNT_W-1:0]    frm_cnt;
`endif

    uart_rx_frame_chk #(
        .DATA_W(DATA_W), .PRESC_W(PRESC_W), .BITCNT_W(BITCNT_W), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RST(RST), .chk_en(chk_en), .sampled_bit(sampled_bit),
        .prescale(prescale), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
        .par_en(par_en), .par_typ(par_typ), .err_clr(err_clr),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .frame_vld(frame_vld), .rx_data(rx_data), .err_sticky(err_sticky),
        .chk_busy(chk_busy)
`ifdef UART_RX_ERR_CNT_EN
        , .strt_cnt(strt_cnt), .par_cnt(par_cnt), .stp_cnt(stp_cnt), .frm_cnt(frm_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int n_g, n_p, n_s, n_v;

    // reference model state
    logic [7:0] m_rx;
    logic [2:0] m_sticky;
    int         m_cnt_g, m_cnt_p, m_cnt_s, m_cnt_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
        if (strt_glitch) n_g++;
        if (par_err)     n_p++;
        if (stp_err)     n_s++;
        if (frame_vld)   n_v++;
    endtask

    function automatic int sat(input int c);
        return (c >= CNT_MAX) ? CNT_MAX : c + 1;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "/rx_data"}, 32'(rx_data), 32'(m_rx));
        check({tag, "/err_sticky"}, 32'(err_sticky), 32'(m_sticky));
        check({tag, "/chk_busy"}, 32'(chk_busy), 32'(0));
`ifdef UART_RX_ERR_CNT_EN
        check({tag, "/strt_cnt"}, 32'(strt_cnt), 32'(m_cnt_g));
        check({tag, "/par_cnt"},  32'(par_cnt),  32'(m_cnt_p));
        check({tag, "/stp_cnt"},  32'(stp_cnt),  32'(m_cnt_s));
        check({tag, "/frm_cnt"},  32'(frm_cnt),  32'(m_cnt_v));
`endif
    endtask

    task automatic send_frame(input string tag, input logic sb, input logic [7:0] d,
                              input logic pe, input logic pt, input logic pbit,
                              input logic stpb, input int p, input bit junk,
                              input bit flip, input bit clr_at_stop);
        int   stop;
        logic val;
        logic vld_seen;
        logic exp_g, exp_p, exp_s, exp_v;
        n_g = 0; n_p = 0; n_s = 0; n_v = 0;
        vld_seen = 1'b0;
        stop = 10 + int'(pe);
        prescale = PRESC_W'(p);
        par_en = pe; par_typ = pt;
        chk_en = 1'b1; bit_cnt = '0; edge_cnt = '0; sampled_bit = 1'b1;
        cyc();
        check({tag, "/busy_after_rise"}, 32'(chk_busy), 32'(1));
        if (junk) begin
            bit_cnt = '0; edge_cnt = PRESC_W'(p - 1); sampled_bit = 1'b1;
            cyc();
        end
        for (int b = 1; b <= stop; b++) begin
            if (b == 1)               val = sb;
            else if (b <= 9)          val = d[b-2];
            else if (pe && b == 10)   val = pbit;
            else                      val = stpb;
            for (int e = 0; e < p; e++) begin
                bit_cnt = BITCNT_W'(b); edge_cnt = PRESC_W'(e); sampled_bit = val;
                if (flip && b == 4 && e == 0) begin
                    par_en = ~pe; par_typ = ~pt;
                end
                cyc();
                if (b == stop && e == p - 1) begin
                    vld_seen = frame_vld;
                    if (clr_at_stop) err_clr = 1'b1;
                end
            end
            if (junk && b == 2) begin
                bit_cnt = BITCNT_W'(2); edge_cnt = PRESC_W'(p - 1); sampled_bit = ~val;
                cyc();
            end
        end
        chk_en = 1'b0;
        cyc();
        err_clr = 1'b0;
        cyc();

        exp_g = sb;
        exp_p = !sb && pe && (pbit != ((^d) ^ pt));
        exp_s = !sb && !stpb;
        exp_v = !sb && !exp_p && stpb;
        if (exp_v) m_rx = d;
        if (clr_at_stop) begin
            m_sticky = exp_s ? 3'b100 : 3'b000;
            m_cnt_g = 0; m_cnt_p = 0; m_cnt_s = 0; m_cnt_v = 0;
        end else begin
            m_sticky = m_sticky | {exp_s, exp_p, exp_g};
            if (exp_g) m_cnt_g = sat(m_cnt_g);
            if (exp_p) m_cnt_p = sat(m_cnt_p);
            if (exp_s) m_cnt_s = sat(m_cnt_s);
            if (exp_v) m_cnt_v = sat(m_cnt_v);
        end

        check({tag, "/strt_glitch_cycles"}, 32'(n_g), 32'(exp_g));
        check({tag, "/par_err_cycles"}, 32'(n_p), 32'(exp_p));
        check({tag, "/stp_err_cycles"}, 32'(n_s), 32'(exp_s));
        check({tag, "/frame_vld_cycles"}, 32'(n_v), 32'(exp_v));
        check({tag, "/frame_vld_timing"}, 32'(vld_seen), 32'(exp_v));
        check_state(tag);
    endtask

    task automatic drive_partial(input logic [7:0] d, input int p, input int upto);
        n_g = 0; n_p = 0; n_s = 0; n_v = 0;
        prescale = PRESC_W'(p);
        par_en = 1'b0; par_typ = 1'b0;
        chk_en = 1'b1; bit_cnt = '0; edge_cnt = '0; sampled_bit = 1'b1;
        cyc();
        for (int b = 1; b < upto; b++) begin
            for (int e = 0; e < p; e++) begin
                bit_cnt = BITCNT_W'(b); edge_cnt = PRESC_W'(e);
                sampled_bit = (b == 1) ? 1'b0 : d[b-2];
                cyc();
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       pe, pt, sb, pbit, stpb;

        RST = 1'b0; chk_en = 1'b0; sampled_bit = 1'b1; prescale = 6'd8;
        edge_cnt = '0; bit_cnt = '0; par_en = 1'b0; par_typ = 1'b0; err_clr = 1'b0;
        m_rx = '0; m_sticky = '0; m_cnt_g = 0; m_cnt_p = 0; m_cnt_s = 0; m_cnt_v = 0;
        #1;
        check("reset/pulses", 32'({strt_glitch, par_err, stp_err, frame_vld}), 32'(0));
        check_state("reset");
        @(negedge CLK); @(negedge CLK);
        RST = 1'b1;
        cyc();

        // directed frames
        send_frame("a5_even",     1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0, 1'b0);
        send_frame("3c_odd_bad",  1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 8, 1'b0, 1'b0, 1'b0);
        send_frame("glitch",      1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0, 1'b0);
        send_frame("after_glitch",1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b0);
        send_frame("7e_stop_clr", 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            send_frame("stop_sat", 1'b0, 8'(i * 37), 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0);

        // err_clr while idle
        err_clr = 1'b1; cyc(); err_clr = 1'b0; cyc();
        m_sticky = '0; m_cnt_g = 0; m_cnt_p = 0; m_cnt_s = 0; m_cnt_v = 0;
        check_state("err_clr_idle");

        // mid-frame par_en/par_typ change only affects the next frame
        send_frame("flip_mid",    1'b0, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 5, 1'b0, 1'b1, 1'b0);

        // prescale = 0 never strobes
        n_g = 0; n_p = 0; n_s = 0; n_v = 0;
        prescale = '0; edge_cnt = '1; chk_en = 1'b1; bit_cnt = BITCNT_W'(1); sampled_bit = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        check("presc0/busy", 32'(chk_busy), 32'(1));
        check("presc0/pulses", 32'(n_g + n_p + n_s + n_v), 32'(0));
        chk_en = 1'b0; cyc(); cyc();
        check_state("presc0");

        // chk_en dropped at bit 5 discards the frame
        drive_partial(8'h5A, 4, 5);
        chk_en = 1'b0;
        for (int e = 0; e < 8; e++) begin
            bit_cnt = BITCNT_W'(5 + e / 4); edge_cnt = PRESC_W'(e % 4); sampled_bit = 1'b1;
            cyc();
        end
        check("drop/pulses", 32'(n_g + n_p + n_s + n_v), 32'(0));
        check_state("drop");

        // randomized frames
        for (int i = 0; i < 40; i++) begin
            d    = 8'($urandom);
            pe   = 1'($urandom);
            pt   = 1'($urandom);
            sb   = ($urandom % 10) == 0;
            pbit = (^d) ^ pt;
            if (($urandom % 4) == 0) pbit = ~pbit;
            stpb = ($urandom % 5) != 0;
            send_frame("rand", sb, d, pe, pt, pbit, stpb, int'($urandom_range(1, 6)),
                       ($urandom % 3) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0);
        end

        // asynchronous reset in the middle of a frame
        send_frame("pre_rst_err", 1'b0, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        send_frame("pre_rst_ok",  1'b0, 8'hE7, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
        drive_partial(8'h0F, 3, 7);
        check("rst/busy_before", 32'(chk_busy), 32'(1));
        #2;
        RST = 1'b0;
        #1;
        m_rx = '0; m_sticky = '0; m_cnt_g = 0; m_cnt_p = 0; m_cnt_s = 0; m_cnt_v = 0;
        check("rst/pulses", 32'({strt_glitch, par_err, stp_err, frame_vld}), 32'(0));
        check_state("rst_mid");
        chk_en = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        cyc();
        send_frame("after_rst",   1'b0, 8'h3A, 1'b1, 1'b1, 1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
